shared_round_key_reverse_buffer: RTL and testbench

Two-share round-key store sitting between the shared key expansion datapath and the shared decryption round. It captures the masked round keys in generation order (K0..K16), one per cycle, then replays them in reverse order (K16..K0) over a valid/ready interface so the inverse cipher rounds get their keys without re-running the schedule. Shares are stored, moved and zeroed independently and are never XORed together.

---
 rtl/shared_round_key_reverse_buffer_if.sv | 26 ++
 rtl/shared_round_key_reverse_buffer.sv | 133 +++++++++++++
 tb/tb_shared_round_key_reverse_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_round_key_reverse_buffer_if.sv
// Write and read channels of the two-share round-key reverse buffer.
// The key expansion and decryption round sides drive the master modport; the buffer uses slave.
interface shared_round_key_reverse_buffer_if #(
  parameter int unsigned IDX_W = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [127:0]     wr_share0;
  logic [127:0]     wr_share1;
  logic             rd_valid;
  logic             rd_ready;
  logic [127:0]     rd_share0;
  logic [127:0]     rd_share1;
  logic [IDX_W-1:0] rd_index;
  logic             rd_last;

  modport master (
    output wr_valid, wr_share0, wr_share1, rd_ready,
    input  wr_ready, rd_valid, rd_share0, rd_share1, rd_index, rd_last
  );

  modport slave (
    input  wr_valid, wr_share0, wr_share1, rd_ready,
    output wr_ready, rd_valid, rd_share0, rd_share1, rd_index, rd_last
  );
endinterface

// File: rtl/shared_round_key_reverse_buffer.sv
// Captures masked round keys K0..K(N-1) in generation order and replays them K(N-1)..K0.
// Shares travel in separate storage and registers and are never combined.
module shared_round_key_reverse_buffer #(
  parameter int unsigned NUM_KEYS = 17,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           replay,
  shared_round_key_reverse_buffer_if.slave bus,
  output logic                           loaded,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE, FILL, LOAD, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);

  state_t           state, state_nxt;
  logic [127:0]     mem0 [NUM_KEYS];
  logic [127:0]     mem1 [NUM_KEYS];
  logic [IDX_W-1:0] wr_ptr, rd_ptr, rd_prev;
  logic             loaded_q;
  logic             rd_valid_q, rd_last_q;
  logic [127:0]     rd_share0_q, rd_share1_q;
  logic [IDX_W-1:0] rd_index_q;
  logic             last_wr, last_rd, hs;

  assign rd_prev = rd_ptr - 1'b1;
  assign last_wr = bus.wr_valid && (wr_ptr == LAST);
  assign hs      = rd_valid_q && bus.rd_ready;
  assign last_rd = hs && (rd_ptr == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = FILL;
    end else begin
      unique case (state)
        IDLE:    if (replay && loaded_q) state_nxt = LOAD;
        FILL:    if (last_wr)            state_nxt = LOAD;
        LOAD:                            state_nxt = DRAIN;
        DRAIN:   if (last_rd)            state_nxt = IDLE;
        default:                         state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.wr_ready = (state == FILL);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      loaded_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_index_q  <= '0;
      rd_share0_q <= '0;
      rd_share1_q <= '0;
    end else if (start) begin
      wr_ptr      <= '0;
      loaded_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_index_q  <= '0;
      rd_share0_q <= '0;
      rd_share1_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (replay && loaded_q) rd_ptr <= LAST;
        end
        FILL: begin
          if (bus.wr_valid) begin
            mem0[wr_ptr] <= bus.wr_share0;
            mem1[wr_ptr] <= bus.wr_share1;
            wr_ptr       <= wr_ptr + 1'b1;
            if (last_wr) begin
              loaded_q <= 1'b1;
              rd_ptr   <= LAST;
            end
          end
        end
        LOAD: begin
          rd_share0_q <= mem0[rd_ptr];
          rd_share1_q <= mem1[rd_ptr];
          rd_index_q  <= rd_ptr;
          rd_last_q   <= (rd_ptr == '0);
          rd_valid_q  <= 1'b1;
        end
        DRAIN: begin
          // Prefetch the next-lower key on the handshake edge for one pair per cycle.
          if (last_rd) begin
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_index_q  <= '0;
            rd_share0_q <= '0;
            rd_share1_q <= '0;
          end else if (hs) begin
            rd_ptr      <= rd_prev;
            rd_share0_q <= mem0[rd_prev];
            rd_share1_q <= mem1[rd_prev];
            rd_index_q  <= rd_prev;
            rd_last_q   <= (rd_prev == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_index  = rd_index_q;
  assign bus.rd_share0 = rd_share0_q;
  assign bus.rd_share1 = rd_share1_q;
  assign loaded        = loaded_q;

endmodule

// File: tb/tb_shared_round_key_reverse_buffer.sv
// Directed bench for the round-key reverse buffer: capture, reverse drain, replay, abort and reset.
module tb_shared_round_key_reverse_buffer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic replay = 1'b0;
  logic loaded, busy;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  shared_round_key_reverse_buffer_if #(.IDX_W(5)) bus ();

  shared_round_key_reverse_buffer #(.NUM_KEYS(17), .IDX_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .replay(replay),
    .bus(bus), .loaded(loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] key0(int tag, int i);
    return {32'(tag), 64'h0, 32'(i)};
  endfunction

  function automatic logic [127:0] key1(int tag, int i);
    return ~key0(tag, i);
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bus.wr_ready !== 1'b1 || loaded !== 1'b0 || bus.rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_enter_fill: wr_ready=%b loaded=%b rd_valid=%b busy=%b want 1 0 0 1",
               bus.wr_ready, loaded, bus.rd_valid, busy);
    end
  endtask

  task automatic fill_set(int tag, bit gaps);
    for (int i = 0; i < 17; i++) begin
      if (gaps && (i % 2 == 1)) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
      end
      bus.wr_valid  = 1'b1;
      bus.wr_share0 = key0(tag, i);
      bus.wr_share1 = key1(tag, i);
      checks++;
      if (bus.wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_wr_ready: write %0d wr_ready=%b want 1", i, bus.wr_ready);
      end
      @(negedge clk);
    end
    bus.wr_valid  = 1'b0;
    bus.wr_share0 = '0;
    bus.wr_share1 = '0;
    checks++;
    if (bus.rd_valid !== 1'b0 || busy !== 1'b1 || bus.wr_ready !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL fill_load_cycle: rd_valid=%b busy=%b wr_ready=%b loaded=%b want 0 1 0 1",
               bus.rd_valid, busy, bus.wr_ready, loaded);
    end
    @(negedge clk);
  endtask

  task automatic replay_pulse();
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL replay_load_cycle: rd_valid=%b busy=%b want 0 1", bus.rd_valid, busy);
    end
    @(negedge clk);
  endtask

  // Expects rd_valid already high at the current negedge; stop_at>=0 returns when that index is shown.
  task automatic drain(int tag, logic [31:0] pat, int stop_at);
    int exp = 16;
    int cyc = 0;
    while (exp >= 0 && cyc < 300) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_index !== 5'(exp) || bus.rd_last !== (exp == 0) ||
          bus.rd_share0 !== key0(tag, exp) || bus.rd_share1 !== key1(tag, exp)) begin
        errors++;
        $display("FAIL drain_pair: valid=%b idx=%0d last=%b s0=%h s1=%h want 1 %0d %b %h %h",
                 bus.rd_valid, bus.rd_index, bus.rd_last, bus.rd_share0, bus.rd_share1,
                 exp, exp == 0, key0(tag, exp), key1(tag, exp));
      end
      if (exp == stop_at) return;
      bus.rd_ready = pat[cyc % 32];
      @(negedge clk);
      if (bus.rd_ready) exp--;
      cyc++;
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL drain_timeout: %0d cycles, index still %0d want -1", cyc, exp);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_share0 !== '0 || bus.rd_share1 !== '0 ||
        bus.rd_index !== '0 || bus.rd_last !== 1'b0 || busy !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: valid=%b s0=%h s1=%h idx=%0d last=%b busy=%b loaded=%b want 0 0 0 0 0 0 1",
               bus.rd_valid, bus.rd_share0, bus.rd_share1, bus.rd_index, bus.rd_last, busy, loaded);
    end
  endtask

  task automatic check_quiet(string name);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_share0 !== '0 || bus.rd_share1 !== '0 || bus.rd_index !== '0 ||
        bus.rd_last !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b s0=%h s1=%h idx=%0d last=%b busy=%b loaded=%b wr_ready=%b want all 0",
               name, bus.rd_valid, bus.rd_share0, bus.rd_share1, bus.rd_index, bus.rd_last,
               busy, loaded, bus.wr_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_quiet("reset_values");
    rstn = 1'b1;
    @(negedge clk);
    check_quiet("after_release");
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("replay_unloaded_ignored");
    end
  endtask

  task automatic test_basic_reverse();
    start_pulse();
    fill_set(0, 1'b0);
    drain(0, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_backpressure_replay();
    replay_pulse();
    drain(0, 32'hB5A3_6C91, -1);
  endtask

  task automatic test_write_gaps_ignored();
    start_pulse();
    fill_set(2, 1'b1);
    drain(2, 32'hFFFF_FFFF, -1);
    bus.wr_valid  = 1'b1;
    bus.wr_share0 = JUNK;
    bus.wr_share1 = ~JUNK;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.wr_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_write_ignored: wr_ready=%b busy=%b want 0 0", bus.wr_ready, busy);
      end
    end
    replay_pulse();
    drain(2, 32'h6DB6_DB6D, -1);
    bus.wr_valid = 1'b0;
    replay_pulse();
    drain(2, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_abort();
    replay_pulse();
    drain(2, 32'hFFFF_FFFF, 9);
    start = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || loaded !== 1'b0 || bus.rd_share0 !== '0 || bus.rd_share1 !== '0 ||
        bus.rd_index !== '0 || bus.wr_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: valid=%b loaded=%b s0=%h s1=%h idx=%0d wr_ready=%b busy=%b want 0 0 0 0 0 1 1",
               bus.rd_valid, loaded, bus.rd_share0, bus.rd_share1, bus.rd_index, bus.wr_ready, busy);
    end
    fill_set(3, 1'b0);
    drain(3, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_reset_mid_fill();
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid  = 1'b1;
      bus.wr_share0 = key0(5, i);
      bus.wr_share1 = key1(5, i);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_quiet("async_reset_mid_fill");
    @(negedge clk);
    rstn = 1'b1;
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("replay_after_reset_ignored");
    end
    start_pulse();
    fill_set(4, 1'b0);
    drain(4, 32'hFFFF_FFFF, -1);
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_share0 = '0;
    bus.wr_share1 = '0;
    bus.rd_ready  = 1'b0;
    test_reset();
    test_basic_reverse();
    test_backpressure_replay();
    test_write_gaps_ignored();
    test_abort();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
